// File: rtl/femtorv_bus_arbiter.sv
// femtorv_bus_arbiter: two-master round-robin arbiter for the FemtoRV32 bus.
// Each master owns a one-deep request slot and is stalled via rbusy/wbusy.
module femtorv_bus_arbiter #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_rbusy,
  output logic        m0_wbusy,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_rbusy,
  output logic        m1_wbusy,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_rstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_rbusy,
  input  logic        s_wbusy,
  output logic        err_overflow
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state;
  logic [1:0]            slotValid;
  logic [ADDR_WIDTH-1:0] slotAddr  [2];
  logic [31:0]           slotWdata [2];
  logic [3:0]            slotWmask [2];
  logic [1:0]            slotIsRead;
  logic [ADDR_WIDTH-1:0] actAddr;
  logic [31:0]           actWdata;
  logic                  actIsRead;
  logic                  owner;
  logic                  lastGrant;
  logic [31:0]           rdataQ [2];

  logic [ADDR_WIDTH-1:0] mAddr  [2];
  logic [31:0]           mWdata [2];
  logic [3:0]            mWmask [2];
  logic [1:0]            mReq;
  logic                  grant;
  logic                  issue;
  logic                  complete;
  logic [1:0]            clrSlot;
  logic [1:0]            busy;

  assign mAddr[0]  = m0_addr[ADDR_WIDTH-1:0];
  assign mAddr[1]  = m1_addr[ADDR_WIDTH-1:0];
  assign mWdata[0] = m0_wdata;
  assign mWdata[1] = m1_wdata;
  assign mWmask[0] = m0_wmask;
  assign mWmask[1] = m1_wmask;
  assign mReq[0]   = m0_rstrb | (|m0_wmask);
  assign mReq[1]   = m1_rstrb | (|m1_wmask);

  if (ADDR_WIDTH < 32) begin : gUnusedHi
    logic unusedHi;
    assign unusedHi = ^{m0_addr[31:ADDR_WIDTH],
                        m1_addr[31:ADDR_WIDTH]};
  end

  // On a tie the master that was not served last wins.
  assign grant    = (&slotValid) ? ~lastGrant : slotValid[1];
  assign issue    = (state == IDLE) & (|slotValid);
  assign complete = (state == WAIT) &
                    (actIsRead ? ~s_rbusy : ~s_wbusy);
  assign clrSlot  = {issue & grant, issue & ~grant};

  assign busy[0] = slotValid[0] |
                   ((state == WAIT) & ~owner & ~complete);
  assign busy[1] = slotValid[1] |
                   ((state == WAIT) & owner & ~complete);

  assign m0_rbusy = busy[0];
  assign m0_wbusy = busy[0];
  assign m1_rbusy = busy[1];
  assign m1_wbusy = busy[1];

  assign m0_rdata = (complete & actIsRead & ~owner) ?
                    s_rdata : rdataQ[0];
  assign m1_rdata = (complete & actIsRead & owner) ?
                    s_rdata : rdataQ[1];

  always_comb begin
    s_rstrb = 1'b0;
    s_wmask = 4'b0;
    s_addr  = 32'(actAddr);
    s_wdata = actWdata;
    if (issue) begin
      s_rstrb = slotIsRead[grant];
      s_wmask = slotWmask[grant];
      s_addr  = 32'(slotAddr[grant]);
      s_wdata = slotWdata[grant];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      slotValid    <= '0;
      actAddr      <= '0;
      actWdata     <= '0;
      actIsRead    <= 1'b0;
      owner        <= 1'b0;
      lastGrant    <= 1'b1;
      rdataQ[0]    <= '0;
      rdataQ[1]    <= '0;
      err_overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            state     <= WAIT;
            actAddr   <= slotAddr[grant];
            actWdata  <= slotWdata[grant];
            actIsRead <= slotIsRead[grant];
            owner     <= grant;
            lastGrant <= grant;
          end
        end
        WAIT: begin
          if (complete) begin
            state <= IDLE;
            if (actIsRead) rdataQ[owner] <= s_rdata;
          end
        end
      endcase
      // A slot freed by this cycle's issue may be refilled at once.
      for (int i = 0; i < 2; i++) begin
        if (mReq[i]) begin
          if (slotValid[i] & ~clrSlot[i]) begin
            err_overflow <= 1'b1;
          end else begin
            slotValid[i]  <= 1'b1;
            slotAddr[i]   <= mAddr[i];
            slotWdata[i]  <= mWdata[i];
            slotWmask[i]  <= mWmask[i];
            slotIsRead[i] <= ~|mWmask[i];
          end
        end else if (clrSlot[i]) begin
          slotValid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_femtorv_bus_arbiter.sv
// tb_femtorv_bus_arbiter: directed and random stimulus for the bus arbiter.
// A transaction-level model predicts every output each cycle.
module tb_femtorv_bus_arbiter;

  localparam int AW = 24;
  localparam logic [31:0] AMASK = (32'd1 << AW) - 32'd1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
  } mreq_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rd;
  } txn_t;

  logic        clk;
  logic        reset;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wmask;
  logic        m0_rstrb, m0_rbusy, m0_wbusy;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic        m1_rstrb, m1_rbusy, m1_wbusy;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb, s_rbusy, s_wbusy;
  logic        err_overflow;

  femtorv_bus_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy),
    .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy),
    .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy),
    .s_wbusy(s_wbusy),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;

  // Reference model: pending request per master, one slave transaction.
  bit          pv [2];
  txn_t        pt [2];
  bit          inTx;
  txn_t        cur;
  int          own;
  int          lastG;
  logic [31:0] rq [2];
  bit          ovf;
  int          waitLeft;
  bit          addrKnown;
  int          forcedWait;

  mreq_t       nx [2];
  logic [31:0] nxRdata;
  bit          nxRst;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit done, iss, eb;
    int g;
    logic [31:0] eRd;
    @(negedge clk);
    reset    = !nxRst;
    m0_addr  = nx[0].addr;
    m0_wdata = nx[0].wdata;
    m0_wmask = nx[0].wmask;
    m0_rstrb = nx[0].rstrb;
    m1_addr  = nx[1].addr;
    m1_wdata = nx[1].wdata;
    m1_wmask = nx[1].wmask;
    m1_rstrb = nx[1].rstrb;
    s_rdata  = nxRdata;
    s_rbusy  = 1'($urandom);
    s_wbusy  = 1'($urandom);
    if (inTx && cur.rd)  s_rbusy = (waitLeft > 0);
    if (inTx && !cur.rd) s_wbusy = (waitLeft > 0);
    #1;
    done = inTx && (cur.rd ? !s_rbusy : !s_wbusy);
    iss  = !inTx && (pv[0] || pv[1]);
    g    = (pv[0] && pv[1]) ? 1 - lastG : (pv[1] ? 1 : 0);
    if (!nxRst) begin
      if (iss) begin
        chk("s_rstrb", s_rstrb, pt[g].rd);
        chk("s_wmask", s_wmask, pt[g].wmask);
        chk("s_addr", s_addr, pt[g].addr);
        chk("s_wdata", s_wdata, pt[g].wdata);
      end else begin
        chk("s_rstrb", s_rstrb, 0);
        chk("s_wmask", s_wmask, 0);
        if (inTx || addrKnown) begin
          chk("s_addr_hold", s_addr, cur.addr);
          chk("s_wdata_hold", s_wdata, cur.wdata);
        end
      end
      for (int x = 0; x < 2; x++) begin
        eb  = pv[x] || (inTx && own == x && !done);
        eRd = (done && cur.rd && own == x) ? s_rdata : rq[x];
        chk($sformatf("m%0d_rbusy", x),
            x == 0 ? m0_rbusy : m1_rbusy, eb);
        chk($sformatf("m%0d_wbusy", x),
            x == 0 ? m0_wbusy : m1_wbusy, eb);
        chk($sformatf("m%0d_rdata", x),
            x == 0 ? m0_rdata : m1_rdata, eRd);
      end
      chk("err_overflow", err_overflow, ovf);
    end
    if (nxRst) begin
      pv = '{0, 0};
      inTx = 0;
      cur = '0;
      own = 0;
      lastG = 1;
      rq = '{0, 0};
      ovf = 0;
      addrKnown = 1;
    end else begin
      if (inTx) begin
        if (done) begin
          if (cur.rd) rq[own] = s_rdata;
          inTx = 0;
        end else begin
          waitLeft--;
        end
      end else if (iss) begin
        cur = pt[g];
        pv[g] = 0;
        own = g;
        lastG = g;
        inTx = 1;
        addrKnown = 0;
        waitLeft = forcedWait >= 0 ? forcedWait
                                   : $urandom_range(0, 3);
      end
      for (int x = 0; x < 2; x++) begin
        if (nx[x].rstrb || nx[x].wmask != 0) begin
          if (pv[x]) begin
            ovf = 1;
          end else begin
            pv[x] = 1;
            pt[x] = '{addr: nx[x].addr & AMASK,
                      wdata: nx[x].wdata,
                      wmask: nx[x].wmask,
                      rd: nx[x].wmask == 0};
          end
        end
      end
    end
    nx[0]   = '0;
    nx[1]   = '0;
    nxRst   = 0;
    nxRdata = $urandom;
  endtask

  function automatic mreq_t rdReq(input logic [31:0] a);
    return '{addr: a, wdata: 32'h0, wmask: 4'h0, rstrb: 1'b1};
  endfunction

  function automatic mreq_t wrReq(input logic [31:0] a,
                                  input logic [31:0] d,
                                  input logic [3:0] m);
    return '{addr: a, wdata: d, wmask: m, rstrb: 1'b0};
  endfunction

  function automatic mreq_t rndReq();
    mreq_t r;
    int k;
    r = '0;
    k = $urandom_range(0, 9);
    r.addr  = $urandom;
    r.wdata = $urandom;
    if (k == 2 || k == 3 || k == 4)
      r.wmask = 4'($urandom_range(1, 15));
    r.rstrb = (k == 0 || k == 1 || k == 4);
    return r;
  endfunction

  initial begin
    clk = 0;
    reset = 0;
    {m0_addr, m0_wdata, m0_wmask, m0_rstrb} = '0;
    {m1_addr, m1_wdata, m1_wmask, m1_rstrb} = '0;
    {s_rdata, s_rbusy, s_wbusy} = '0;
    nx[0] = '0;
    nx[1] = '0;
    nxRdata = 0;
    forcedWait = 0;
    inTx = 0;
    cur = '0;
    nxRst = 1; cyc();
    nxRst = 1; cyc();
    cyc();
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_rstrb", s_rstrb, 0);
    chk("rst_m0_rdata", m0_rdata, 0);

    // single read
    nx[0] = rdReq(32'h10); cyc();
    chk("rd_busy_T", m0_rbusy, 0);
    cyc();
    chk("rd_strb_T1", s_rstrb, 1);
    chk("rd_busy_T1", m0_rbusy, 1);
    chk("rd_addr_T1", s_addr, 32'h10);
    nxRdata = 32'hDEADBEEF; cyc();
    chk("rd_data_T2", m0_rdata, 32'hDEADBEEF);
    chk("rd_busy_T2", m0_rbusy, 0);
    chk("rd_m1_busy", m1_rbusy, 0);
    cyc();

    // tie after reset, then m0 re-requests so m1 wins the next tie
    nxRst = 1; cyc();
    nx[0] = rdReq(32'h100);
    nx[1] = wrReq(32'h200, 32'h55, 4'b0001); cyc();
    nx[0] = rdReq(32'h104); cyc();
    chk("tie_m0_T1", s_rstrb, 1);
    chk("tie_m0_addr", s_addr, 32'h100);
    cyc();
    chk("tie_m1_busy", m1_wbusy, 1);
    cyc();
    chk("tie_m1_T3", s_wmask, 4'b0001);
    chk("tie_m1_addr", s_addr, 32'h200);
    chk("tie_m1_data", s_wdata, 32'h55);
    cyc(); cyc();
    chk("tie_m0b_T5", s_rstrb, 1);
    cyc(); cyc();
    nx[0] = rdReq(32'h108);
    nx[1] = wrReq(32'h208, 32'h66, 4'b0011); cyc();
    cyc();
    chk("tie2_m1_first", s_wmask, 4'b0011);
    chk("tie2_no_rd", s_rstrb, 0);
    cyc(); cyc();
    chk("tie2_m0_next", s_rstrb, 1);
    cyc(); cyc();

    // slave wait states
    forcedWait = 3;
    nx[1] = rdReq(32'h300); cyc();
    cyc();
    chk("ws_strb", s_rstrb, 1);
    for (int k = 2; k <= 4; k++) begin
      cyc();
      chk("ws_busy", m1_rbusy, 1);
      chk("ws_addr", s_addr, 32'h300);
    end
    nxRdata = 32'hCAFEF00D; cyc();
    chk("ws_done_busy", m1_rbusy, 0);
    chk("ws_data", m1_rdata, 32'hCAFEF00D);
    forcedWait = 0;
    cyc();

    // store then fetch
    nx[0] = wrReq(32'h40, 32'h12345678, 4'hF); cyc();
    nx[0] = rdReq(32'h44); cyc();
    chk("sf_wr_T1", s_wmask, 4'hF);
    cyc(); cyc();
    chk("sf_rd_T3", s_rstrb, 1);
    chk("sf_rd_addr", s_addr, 32'h44);
    chk("sf_no_ovf", err_overflow, 0);
    cyc();

    // overflow, then reset during WAIT
    forcedWait = 5;
    nx[0] = rdReq(32'h500); cyc();
    cyc();
    nx[1] = rdReq(32'h600); cyc();
    nx[1] = rdReq(32'h604); cyc();
    cyc();
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_m1_busy", m1_rbusy, 1);
    chk("ovf_m0_busy", m0_rbusy, 1);
    nxRst = 1; cyc();
    cyc();
    chk("mrst_ovf", err_overflow, 0);
    chk("mrst_m0_busy", m0_rbusy, 0);
    chk("mrst_m1_busy", m1_rbusy, 0);
    chk("mrst_s_addr", s_addr, 0);
    chk("mrst_m0_rdata", m0_rdata, 0);
    cyc();
    chk("mrst_idle", s_rstrb, 0);

    // random traffic
    forcedWait = -1;
    for (int n = 0; n < 4000; n++) begin
      nx[0] = rndReq();
      nx[1] = rndReq();
      nxRst = ($urandom_range(0, 255) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nMis);
    $finish;
  end

endmodule
